// File: rtl/cla_seq_word_adder_pkg.sv
// rtl/cla_seq_word_adder_pkg.sv - shared constants, FSM state type and nibble-count helper
package cla_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int nib_count(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/cla_seq_word_adder_if.sv
// rtl/cla_seq_word_adder_if.sv - operand/result handshake bundle; ovf exists only with CLA_OVF_EN
interface cla_seq_word_adder_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef CLA_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
`ifdef CLA_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
`ifdef CLA_OVF_EN
    , output ovf
`endif
  );

endinterface

// File: rtl/cla_seq_word_adder_cla4_slice.sv
// rtl/cla_seq_word_adder_cla4_slice.sv - combinational 4-bit carry-lookahead slice
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co,
  output logic       c3
);

  logic [3:0] g;
  logic [3:0] p;
  logic       c1;
  logic       c2;

  assign g = a & b;
  assign p = a ^ b;

  // Flat two-level lookahead: every carry is a sum of products of g/p/ci.
  assign c1 = g[0] | (p[0] & ci);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s = p ^ {c3, c2, c1, ci};

endmodule

// File: rtl/cla_seq_word_adder.sv
// rtl/cla_seq_word_adder.sv - nibble-serial WIDTH-bit adder on one reused CLA slice; CLA_OVF_EN adds ovf
module cla_seq_word_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic                  clk,
  input logic                  rst,
  cla_seq_word_adder_if.slave  bus
);

  localparam int NIB   = nib_count(WIDTH);
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  state_e             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   sum_q;
  logic               carry_q;
  logic               cout_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [IDX_W-1:0]   idx_q;

  logic [NIBBLE_W-1:0] nib_a_d;
  logic [NIBBLE_W-1:0] nib_b_d;
  logic [NIBBLE_W-1:0] nib_s_d;
  logic                nib_co_d;
  logic                nib_c3_d;
  logic                last_d;

  assign nib_a_d = a_q[NIBBLE_W*idx_q +: NIBBLE_W];
  assign nib_b_d = b_q[NIBBLE_W*idx_q +: NIBBLE_W];
  assign last_d  = (idx_q == IDX_W'(NIB - 1));

  cla4_slice u_slice (
    .a  (nib_a_d),
    .b  (nib_b_d),
    .ci (carry_q),
    .s  (nib_s_d),
    .co (nib_co_d),
    .c3 (nib_c3_d)
  );

`ifdef CLA_OVF_EN
  logic ovf_q;
  assign bus.ovf = ovf_q;
`else
  logic unused_c3;
  assign unused_c3 = nib_c3_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      idx_q       <= '0;
`ifdef CLA_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            a_q        <= bus.a;
            b_q        <= bus.b;
            carry_q    <= bus.cin;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          sum_q[NIBBLE_W*idx_q +: NIBBLE_W] <= nib_s_d;
          carry_q <= nib_co_d;
          idx_q   <= idx_q + 1'b1;
          if (last_d) begin
            cout_q      <= nib_co_d;
`ifdef CLA_OVF_EN
            // Top nibble's c3 is the carry into bit WIDTH-1.
            ovf_q       <= nib_c3_d ^ nib_co_d;
`endif
            idx_q       <= '0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          // Return to IDLE first so a waiting producer is never accepted in this cycle.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

endmodule

// File: tb/tb_cla_seq_word_adder.sv
// tb/tb_cla_seq_word_adder.sv - self-checking bench: vector table, corner sequences, random vs arithmetic model
module tb_cla_seq_word_adder;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cla_seq_word_adder_if #(.WIDTH(WIDTH)) bus ();

  cla_seq_word_adder #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        output logic [15:0] s, output logic co, output logic ov, output int lat);
    @(negedge clk);
    check("in_ready_idle", {31'd0, bus.in_ready}, 32'd1);
    bus.a = a; bus.b = b; bus.cin = cin; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = 16'($urandom); bus.b = 16'($urandom); bus.cin = 1'($urandom);
    check("in_ready_run", {31'd0, bus.in_ready}, 32'd0);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    s  = bus.sum;
    co = bus.cout;
`ifdef CLA_OVF_EN
    ov = bus.ovf;
`else
    ov = 1'b0;
`endif
  endtask

  task automatic release_result();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("out_valid_drop", {31'd0, bus.out_valid}, 32'd0);
    check("in_ready_back", {31'd0, bus.in_ready}, 32'd1);
  endtask

  task automatic op_and_check(input string tag, input logic [15:0] a, input logic [15:0] b,
                              input logic cin, input logic [15:0] es, input logic eco, input logic eov);
    logic [15:0] s;
    logic co, ov;
    int lat;
    run_op(a, b, cin, s, co, ov, lat);
    check({tag, "_lat"}, lat, NIB);
    check({tag, "_sum"}, {16'd0, s}, {16'd0, es});
    check({tag, "_cout"}, {31'd0, co}, {31'd0, eco});
`ifdef CLA_OVF_EN
    check({tag, "_ovf"}, {31'd0, ov}, {31'd0, eov});
`else
    if (eov !== eov) check({tag, "_ovf"}, {31'd0, ov}, 32'd0);
`endif
    release_result();
  endtask

  initial begin
    logic [16:0] full;
    logic [15:0] ra, rb;
    logic        rc, mov;

    vecs[0] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
    vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[3] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0};
    vecs[4] = '{16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[5] = '{16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0};
    vecs[6] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[8] = '{16'h0001, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[9] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};

    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_sum", {16'd0, bus.sum}, 32'd0);
    check("rst_cout", {31'd0, bus.cout}, 32'd0);
`ifdef CLA_OVF_EN
    check("rst_ovf", {31'd0, bus.ovf}, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      op_and_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                   vecs[i].s, vecs[i].co, vecs[i].ov);

    // Result held under back-pressure; new operands offered meanwhile must be ignored.
    begin
      logic [15:0] s;
      logic co, ov;
      int lat;
      run_op(16'h00FF, 16'h0F01, 1'b0, s, co, ov, lat);
      check("hold_lat", lat, NIB);
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        bus.in_valid = 1'b1; bus.a = 16'h1234; bus.b = 16'h1111; bus.cin = 1'b1;
        @(posedge clk); #1;
        check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
        check("hold_sum", {16'd0, bus.sum}, 32'h1000);
        check("hold_cout", {31'd0, bus.cout}, 32'd0);
        check("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
      end
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      check("turnaround_valid", {31'd0, bus.out_valid}, 32'd0);
      check("turnaround_ready", {31'd0, bus.in_ready}, 32'd1);
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      @(posedge clk); #1;
      check("turnaround_idle", {31'd0, bus.in_ready}, 32'd1);
    end

    // Reset two cycles into RUN discards the operation.
    @(negedge clk);
    bus.a = 16'hAAAA; bus.b = 16'h5555; bus.cin = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrun_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("midrun_rst_sum", {16'd0, bus.sum}, 32'd0);
    check("midrun_rst_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      check("after_rst_no_valid", {31'd0, bus.out_valid}, 32'd0);
    end
    op_and_check("post_rst", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);

    // Reset while the result is waiting in DONE.
    begin
      logic [15:0] s;
      logic co, ov;
      int lat;
      run_op(16'hFFFF, 16'h0001, 1'b0, s, co, ov, lat);
      check("done_rst_pre_valid", {31'd0, bus.out_valid}, 32'd1);
      rst = 1'b1;
      #1;
      check("done_rst_valid", {31'd0, bus.out_valid}, 32'd0);
      check("done_rst_cout", {31'd0, bus.cout}, 32'd0);
      check("done_rst_ready", {31'd0, bus.in_ready}, 32'd1);
      @(negedge clk);
      rst = 1'b0;
    end

    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      if (i % 8 == 0) rb = 16'hFFFF - ra;
      full = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
      mov  = (ra[15] == rb[15]) && (full[15] != ra[15]);
      op_and_check($sformatf("rnd%0d", i), ra, rb, rc, full[15:0], full[16], mov);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
